psum_accum: RTL and testbench
=============================

# psum_accum

Consumer end of the dot-product datapath. It accepts the stream of `2*DATA_WIDTH+2`-bit partial sums produced by the `WEIGHT_SIZE`-wide vector multiplier and accumulates `ACC_LEN` consecutive psums into one output pixel. The accumulated result is requantized back to `DATA_WIDTH` by a rounding right shift followed by unsigned saturation. The block sits between the multiplier array and the feature-map writeback, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `DATA_WIDTH`, from `parameters.v` (8): feature/weight width; output width.
- `PSUM_W`, `2*DATA_WIDTH+2` (18): input psum width; must match the multiplier output.
- `ACC_LEN`, 3: psums per output pixel; legal values are ≥1.
- `SHIFT`, 8: requantization right shift; legal range is 0..`ACC_W-1`.
- `ACC_W`, `PSUM_W+$clog2(ACC_LEN+1)`: accumulator width, derived; never overflows.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clr`, in, 1: synchronous flush of the partial accumulation.
- `in_valid`, in, 1: `in_psum` is valid.
- `in_ready`, out, 1: block can accept a psum this cycle.
- `in_psum`, in, `PSUM_W`: unsigned partial sum.
- `out_valid`, out, 1: `out_data`/`out_acc` hold a result.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, `DATA_WIDTH`: requantized, saturated pixel.
- `out_acc`, out, `ACC_W`: raw accumulated sum, for debug and bypass.

## Operation
- Input beat: `in_valid && in_ready`. Output beat: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- State: `cnt` (0..`ACC_LEN-1`), `acc` (`ACC_W` bits), and the output register.
- Phase states:
  - `IDLE`: `cnt==0`.
  - `ACCUM`: `cnt>0`.
  - `FULL` (orthogonal to the phase): `out_valid=1`.
- Non-final input beat (`cnt<ACC_LEN-1`): `acc <= acc + in_psum`, `cnt <= cnt+1`.
- Final input beat (`cnt==ACC_LEN-1`):
  - `sum = acc + in_psum`.
  - `out_acc <= sum`, `out_data <= sat(rnd(sum))`, `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`.
- `ACC_LEN==1`: every input beat is final.
- Rounding:
  - If `SHIFT>0`: `rnd(x) = (x + (1<<(SHIFT-1))) >> SHIFT`, computed at `ACC_W+1` bits so the carry is not lost.
  - If `SHIFT==0`: `rnd(x) = x`.
- Saturation: `sat(y) = (y > 2^DATA_WIDTH-1) ? 2^DATA_WIDTH-1 : y[DATA_WIDTH-1:0]`.
- Output beat with no final input beat in the same cycle: `out_valid <= 0`.
- Output beat and final input beat in the same cycle: the output register loads the new result and `out_valid` stays 1.
- `clr`:
  - Sets `acc <= 0`, `cnt <= 0` and overrides any input beat in that cycle; the beat is discarded and not counted.
  - Does not touch the output register or `out_valid`; a pending result is still delivered.
- Reset (`rst_n=0`, at any time including mid-accumulation): `cnt=0`, `acc=0`, `out_valid=0`, `out_data=0`, `out_acc=0`. `in_ready` is therefore 1 during and after reset.

## Timing
- Latency: the final input beat at edge N makes `out_valid` high from edge N (visible in cycle N+1).
- Throughput: one psum per cycle with `out_ready` held high, so one output every `ACC_LEN` cycles, back to back with no bubble.
- Backpressure:
  - While `out_valid && !out_ready`, `in_ready=0` for all beats, final and non-final.
  - Upstream must hold `in_psum` stable until accepted.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_acc` are stable.
- `clr` and `rst_n` take priority over input beats; `rst_n` over everything.

## Structure
- Shared package / `parameters.v`: `DATA_WIDTH`, `WEIGHT_SIZE`, and a `PSUM_W` macro (`DATA_WIDTH*2+2`). Both the multiplier and this block use the `PSUM_W` macro.
- One sub-module, `requant_sat`: purely combinational rounding shift plus saturate, parameterized by `ACC_W`, `SHIFT`, `DATA_WIDTH`. It is reusable by other writeback paths.
- Top level: counter, accumulator, output register, handshake logic.

## Test plan
- Basic group (`ACC_LEN=3`, `SHIFT=2`, `out_ready=1`): psums 100, 200, 300 on consecutive cycles → one output with `out_acc=600`, `out_data=150`, `out_valid` high for one cycle.
- Rounding: `SHIFT=2`, psums 1, 1, 0 → `out_acc=2`, `out_data=1` (2+2=4, >>2 gives 1). Psums 1, 0, 0 → `out_data=0`.
- Saturation: `SHIFT=8`, three psums of 195075 → `out_acc=585225`, `out_data=255`.
- Backpressure: `out_ready=0` after the first result; a second group of 3 psums is offered → `in_ready=0` and no psums are consumed. Raise `out_ready` → first result is taken, then the second group is accepted and its result produced; the results are neither lost nor duplicated.
- Simultaneous events:
  - Final beat of group 2 in the same cycle as the output beat of group 1 → `out_valid` stays 1 and the next cycle shows the group-2 value.
  - `clr` asserted with `cnt=2`, together with `in_valid` → the beat is dropped; the next 3 psums form a fresh group.
- Reset mid-operation: assert `rst_n=0` after 2 of 3 psums with a result pending → all outputs 0, `in_ready=1`. After release, psums 5, 5, 5 with `SHIFT=0` → `out_data=15`.

Source files
------------

// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: datapath widths shared by the vector multiplier and the
// partial-sum accumulator, plus a small sizing helper.
//   DATA_WIDTH  feature/weight width (also the requantized output width)
//   WEIGHT_SIZE lanes in the vector multiplier
//   PSUM_W      multiplier output width, DATA_WIDTH*2+2
package psum_accum_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int WEIGHT_SIZE = 16;
  localparam int PSUM_W      = DATA_WIDTH*2+2;

  // Width of a 0..len-1 counter; a length-1 counter still needs one bit.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/psum_accum_requant_sat.sv
// requant_sat: combinational requantizer. Rounding right shift by SHIFT
// (round half up) followed by unsigned saturation to DATA_WIDTH bits.
//   acc  in  ACC_W       raw accumulated value
//   q    out DATA_WIDTH  rounded, saturated result
module requant_sat #(
  parameter int ACC_W      = 20,
  parameter int SHIFT      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic [ACC_W-1:0]      acc,
  output logic [DATA_WIDTH-1:0] q
);

  localparam logic [ACC_W:0] QMAX = (ACC_W+1)'({DATA_WIDTH{1'b1}});

  // One extra bit so the rounding carry out of the top is kept.
  logic [ACC_W:0] rnd;

  generate
    if (SHIFT > 0) begin : g_shift
      localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
      logic [ACC_W:0] biased;
      assign biased = {1'b0, acc} + HALF;
      assign rnd    = biased >> SHIFT;
    end else begin : g_noshift
      assign rnd = {1'b0, acc};
    end
  endgenerate

  assign q = (rnd > QMAX) ? {DATA_WIDTH{1'b1}} : rnd[DATA_WIDTH-1:0];

endmodule

// File: rtl/psum_accum.sv
// psum_accum: sums ACC_LEN consecutive partial sums into one output pixel,
// then requantizes it to DATA_WIDTH. Valid/ready on both sides; one psum per
// cycle and back-to-back results while out_ready stays high.
//   clk, rst_n            clock, async active-low reset
//   clr                   sync flush of the partial group (output untouched)
//   in_valid/in_ready     psum handshake, in_psum PSUM_W bits unsigned
//   out_valid/out_ready   result handshake
//   out_data              requantized, saturated pixel
//   out_acc               raw accumulated sum
module psum_accum #(
  parameter int DATA_WIDTH = psum_accum_pkg::DATA_WIDTH,
  parameter int PSUM_W     = 2*DATA_WIDTH+2,
  parameter int ACC_LEN    = 3,
  parameter int SHIFT      = 8,
  parameter int ACC_W      = PSUM_W + $clog2(ACC_LEN+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_W-1:0]     in_psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ACC_W-1:0]      out_acc
);

  import psum_accum_pkg::*;

  localparam int               CNT_W    = cnt_width(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN-1);

  typedef struct packed {
    logic [ACC_W-1:0]      acc;
    logic [DATA_WIDTH-1:0] data;
  } res_t;

  logic [CNT_W-1:0]      cnt;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] q;
  res_t                  res_q;
  logic                  vld;
  logic                  in_fire;
  logic                  out_fire;
  logic                  last;

  // Ready depends only on the output register and out_ready, never in_valid.
  assign in_ready = !vld || out_ready;
  // clr swallows a coincident beat: it is neither summed nor counted.
  assign in_fire  = in_valid && in_ready && !clr;
  assign out_fire = vld && out_ready;
  assign last     = (cnt == CNT_LAST);
  assign sum      = acc + ACC_W'(in_psum);

  requant_sat #(
    .ACC_W      (ACC_W),
    .SHIFT      (SHIFT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_requant (
    .acc (sum),
    .q   (q)
  );

  // Partial accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_fire) begin
      if (last) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= sum;
      end
    end
  end

  // Output register. A final beat can only be taken when the register is
  // empty or draining this cycle, so loading always wins over clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      res_q <= '0;
    end else if (in_fire && last) begin
      vld   <= 1'b1;
      res_q <= '{acc: sum, data: q};
    end else if (out_fire) begin
      vld   <= 1'b0;
    end
  end

  assign out_valid = vld;
  assign out_data  = res_q.data;
  assign out_acc   = res_q.acc;

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: three instances (SHIFT 0, 2, 8) share one stimulus
// stream. A group model pushes finished sums into a scoreboard; a monitor
// compares every presented result against it.
module tb_psum_accum;

  localparam int ACC_LEN = 3;
  localparam int PSUM_W  = 18;
  localparam int ACC_W   = 20;
  localparam int NDUT    = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic [PSUM_W-1:0]  in_psum = '0;
  logic [NDUT-1:0]    in_ready_a;
  logic [NDUT-1:0]    out_valid_a;
  logic [7:0]         out_data_a [NDUT];
  logic [ACC_W-1:0]   out_acc_a  [NDUT];

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          rnd_mode = 1'b0;
  longint      sb[$];     // finished group sums awaiting delivery
  int unsigned grp[$];    // psums of the group in progress

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      psum_accum #(
        .ACC_LEN (ACC_LEN),
        .SHIFT   ((g == 0) ? 0 : ((g == 1) ? 2 : 8))
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a[g]),
        .in_psum   (in_psum),
        .out_valid (out_valid_a[g]),
        .out_ready (out_ready),
        .out_data  (out_data_a[g]),
        .out_acc   (out_acc_a[g])
      );
    end
  endgenerate

  function automatic int shift_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 8);
  endfunction

  // Round half up, then clamp to 8 bits.
  function automatic longint ref_q(input longint s, input int sh);
    longint r;
    if (sh == 0) r = s;
    else         r = (s + (longint'(1) << (sh-1))) >> sh;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Entered and left just after a rising edge.
  task automatic step(input bit v, input int unsigned p, input bit c, output bit took);
    bit exp_rdy;
    in_valid = v;
    in_psum  = PSUM_W'(p);
    clr      = c;
    @(negedge clk);
    exp_rdy = (sb.size() == 0) || out_ready;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("in_ready[sh%0d]", shift_of(g)), in_ready_a[g], exp_rdy);
    took = v && !c && exp_rdy;
    @(posedge clk);
    if (c) begin
      grp.delete();
    end else if (took) begin
      grp.push_back(p);
      if (grp.size() == ACC_LEN) begin
        longint s = 0;
        foreach (grp[i]) s += grp[i];
        sb.push_back(s);
        grp.delete();
      end
    end
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) begin
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
      step(1'b0, 0, 1'b0, t);
    end
  endtask

  // Offer a psum and hold it until taken.
  task automatic send(input int unsigned p);
    bit t;
    for (int k = 0; k < 100; k++) begin
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
      step(1'b1, p, 1'b0, t);
      if (t) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    grp.delete();
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("rst in_ready[sh%0d]", shift_of(g)), in_ready_a[g], 1);
      chk($sformatf("rst out_valid[sh%0d]", shift_of(g)), out_valid_a[g], 0);
      chk($sformatf("rst out_data[sh%0d]", shift_of(g)), out_data_a[g], 0);
      chk($sformatf("rst out_acc[sh%0d]", shift_of(g)), out_acc_a[g], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle, valid must track the scoreboard, and a presented
  // result must match its head; the head retires on an output beat.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("out_valid[sh%0d]", shift_of(g)), out_valid_a[g], sb.size() > 0);
        if (out_valid_a[g] && sb.size() > 0) begin
          chk($sformatf("out_acc[sh%0d]", shift_of(g)), out_acc_a[g], sb[0]);
          chk($sformatf("out_data[sh%0d]", shift_of(g)), out_data_a[g], ref_q(sb[0], shift_of(g)));
        end
      end
      if (sb.size() > 0 && out_ready) void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit t;
    // Reset state at time 0, before any edge.
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("init in_ready[sh%0d]", shift_of(g)), in_ready_a[g], 1);
      chk($sformatf("init out_valid[sh%0d]", shift_of(g)), out_valid_a[g], 0);
      chk($sformatf("init out_acc[sh%0d]", shift_of(g)), out_acc_a[g], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic group, rounding and saturation, back to back.
    out_ready = 1'b1;
    send(100); send(200); send(300);
    send(1);   send(1);   send(0);
    send(1);   send(0);   send(0);
    send(195075); send(195075); send(195075);
    idle(2);

    // Backpressure: result held, next group refused until out_ready rises.
    send(10); send(20); send(30);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 40, 1'b0, t);
      chk("bp_not_taken", t, 0);
    end
    out_ready = 1'b1;
    send(40); send(50); send(60);
    send(7);  send(8);  send(9);
    idle(1);

    // clr with cnt==2 and a coincident beat: beat dropped, fresh group next.
    send(1000); send(2000);
    step(1'b1, 3000, 1'b1, t);
    send(4); send(5); send(6);
    idle(1);

    // Reset mid-accumulation, then reset with a result pending.
    send(11); send(12);
    do_reset();
    send(5); send(5); send(5);
    idle(1);
    out_ready = 1'b0;
    send(1); send(2); send(3);
    idle(1);
    do_reset();
    out_ready = 1'b1;
    send(5); send(5); send(5);
    idle(1);

    // Randomized traffic: gaps, backpressure, occasional clr, wide values.
    rnd_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < ACC_LEN; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 39) == 0) begin
          out_ready = 1'($urandom_range(0, 1));
          step(1'($urandom_range(0, 1)), $urandom_range(0, 262143), 1'b1, t);
        end
        if ($urandom_range(0, 1) == 0) send($urandom_range(0, 262143));
        else                           send($urandom_range(250000, 262143));
      end
    end

    // Drain and confirm nothing was lost.
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
